// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared interrupt widths and line mode constants
package irq_pkg;

  localparam int IRQ_NLINES = 8;
  localparam int IRQ_IDX_W  = 3;

  // Per-line mode as driven on edge_sel.
  localparam logic IRQ_LEVEL = 1'b0;
  localparam logic IRQ_EDGE  = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - single-line flop-chain synchronizer
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_source.sv
// rtl/irq_source.sv - interrupt line conditioner feeding the interrupt sequencer
module irq_source
  import irq_pkg::*;
#(
  parameter int NLINES      = IRQ_NLINES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NLINES-1:0]    irq_in,
  input  logic [NLINES-1:0]    edge_sel,
  input  logic [NLINES-1:0]    mask,
  input  logic                 irq_busy,
  input  logic                 swi_we,
  input  logic [NLINES-1:0]    swi_data,
  input  logic                 clr_we,
  input  logic [NLINES-1:0]    clr_data,
  input  logic                 ovr_clr_we,
  input  logic [NLINES-1:0]    ovr_clr_data,
  output logic [NLINES-1:0]    interrupts,
  output logic [NLINES-1:0]    pending,
  output logic [NLINES-1:0]    overrun,
  output logic [IRQ_IDX_W-1:0] taken_idx,
  output logic                 taken_valid
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  // Lowest index wins, matching the sequencer's priority order.
  function automatic logic [IRQ_IDX_W-1:0] lowest_idx(input logic [NLINES-1:0] v);
    lowest_idx = '0;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IRQ_IDX_W'(i);
    end
  endfunction

  logic [NLINES-1:0]    s;
  logic [NLINES-1:0]    p;
  logic [2:0]           arm_cnt;
  logic                 armed;
  logic                 busy_q;
  logic                 busy_rise;
  logic [NLINES-1:0]    edge_ev;
  logic [NLINES-1:0]    level_req;
  logic [NLINES-1:0]    cand;
  logic                 ack_hit;
  logic [IRQ_IDX_W-1:0] ack_idx;
  logic [NLINES-1:0]    ack_bit;
  logic [NLINES-1:0]    set_bits;
  logic [NLINES-1:0]    clr_bits;
  logic [NLINES-1:0]    ovr_set;
  logic [NLINES-1:0]    ovr_clr;

  for (genvar g = 0; g < NLINES; g++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .d     (irq_in[g]),
      .q     (s[g])
    );
  end

  // Arm window hides the synchronizer fill so lines held high through reset make no edge.
  assign armed     = (arm_cnt == ARM_MAX);
  assign busy_rise = irq_busy & ~busy_q;

  always_comb begin
    edge_ev   = '0;
    level_req = '0;
    for (int i = 0; i < NLINES; i++) begin
      edge_ev[i]   = (edge_sel[i] == IRQ_EDGE) & armed & s[i] & ~p[i];
      level_req[i] = (edge_sel[i] == IRQ_LEVEL) & s[i];
    end
  end

  assign interrupts = pending | level_req;
  assign cand       = interrupts & mask;
  assign ack_hit    = busy_rise & (|cand);
  assign ack_idx    = lowest_idx(cand);
  assign ack_bit    = ack_hit ? (NLINES'(1) << ack_idx) : '0;

  // Any set source overrides any clear source on the same bit.
  assign set_bits = edge_ev | (swi_we ? swi_data : '0);
  assign clr_bits = (clr_we ? clr_data : '0) | ack_bit;
  assign ovr_set  = edge_ev & pending;
  assign ovr_clr  = ovr_clr_we ? ovr_clr_data : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p           <= '0;
      arm_cnt     <= '0;
      busy_q      <= 1'b0;
      pending     <= '0;
      overrun     <= '0;
      taken_idx   <= '0;
      taken_valid <= 1'b0;
    end else begin
      p           <= s;
      busy_q      <= irq_busy;
      pending     <= (pending & ~clr_bits) | set_bits;
      overrun     <= (overrun & ~ovr_clr) | ovr_set;
      taken_valid <= ack_hit;
      if (!armed) begin
        arm_cnt <= arm_cnt + 3'd1;
      end
      if (ack_hit) begin
        taken_idx <= ack_idx;
      end
    end
  end

endmodule

// File: tb/tb_irq_source.sv
// tb/tb_irq_source.sv - self-checking bench for irq_source
module tb_irq_source;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] edge_sel = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       irq_busy = 1'b0;
  logic       swi_we = 1'b0;
  logic [7:0] swi_data = 8'h00;
  logic       clr_we = 1'b0;
  logic [7:0] clr_data = 8'h00;
  logic       ovr_clr_we = 1'b0;
  logic [7:0] ovr_clr_data = 8'h00;
  logic [7:0] interrupts;
  logic [7:0] pending;
  logic [7:0] overrun;
  logic [2:0] taken_idx;
  logic       taken_valid;

  int vectors = 0;
  int miscompares = 0;

  irq_source #(.NLINES(8), .SYNC_STAGES(S)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .irq_in       (irq_in),
    .edge_sel     (edge_sel),
    .mask         (mask),
    .irq_busy     (irq_busy),
    .swi_we       (swi_we),
    .swi_data     (swi_data),
    .clr_we       (clr_we),
    .clr_data     (clr_data),
    .ovr_clr_we   (ovr_clr_we),
    .ovr_clr_data (ovr_clr_data),
    .interrupts   (interrupts),
    .pending      (pending),
    .overrun      (overrun),
    .taken_idx    (taken_idx),
    .taken_valid  (taken_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: irq_in log since reset release; s is the line value S edges back.
  logic [7:0] logq[$];
  int         ncnt = 0;
  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_ovr = 8'h00;
  logic [2:0] m_tidx = 3'd0;
  logic       m_tval = 1'b0;
  logic       m_busy_prev = 1'b0;

  function automatic logic [7:0] s_at(input int n);
    if (n >= S) return logq[n - S];
    return 8'h00;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        logq.delete();
        ncnt = 0;
        m_pend = 8'h00;
        m_ovr = 8'h00;
        m_tidx = 3'd0;
        m_tval = 1'b0;
        m_busy_prev = 1'b0;
      end else begin
        logic [7:0] sv, pv, ev, ints, cand, ackb, setb, clrb;
        logic       tv;
        sv   = s_at(ncnt);
        pv   = s_at(ncnt - 1);
        ev   = (ncnt >= S + 1) ? (edge_sel & sv & ~pv) : 8'h00;
        ints = m_pend | (~edge_sel & sv);
        cand = ints & mask;
        ackb = 8'h00;
        tv   = 1'b0;
        if (irq_busy && !m_busy_prev && cand != 8'h00) begin
          tv = 1'b1;
          for (int k = 7; k >= 0; k--) begin
            if (cand[k]) m_tidx = 3'(k);
          end
          ackb = 8'h01 << m_tidx;
        end
        setb   = ev | (swi_we ? swi_data : 8'h00);
        clrb   = (clr_we ? clr_data : 8'h00) | ackb;
        m_ovr  = (m_ovr & ~(ovr_clr_we ? ovr_clr_data : 8'h00)) | (ev & m_pend);
        m_pend = (m_pend & ~clrb) | setb;
        m_tval = tv;
        m_busy_prev = irq_busy;
        logq.push_back(irq_in);
        ncnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("m_interrupts", interrupts, m_pend | (~edge_sel & s_at(ncnt)));
      chk("m_pending", pending, m_pend);
      chk("m_overrun", overrun, m_ovr);
      chk("m_taken_idx", {5'd0, taken_idx}, {5'd0, m_tidx});
      chk("m_taken_valid", {7'd0, taken_valid}, {7'd0, m_tval});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Lines held high through reset must not latch.
    irq_in   = 8'hFF;
    edge_sel = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_pending", pending, 8'h00);
    chk("rst_interrupts", interrupts, 8'h00);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("held_pending", pending, 8'h00);
    chk("held_overrun", overrun, 8'h00);

    // Edge latch latency and overrun.
    @(negedge clk);
    irq_in   = 8'h00;
    edge_sel = 8'h01;
    repeat (4) @(negedge clk);
    irq_in = 8'h01;
    tick();
    chk("edge_e1", pending, 8'h00);
    tick();
    chk("edge_e2", pending, 8'h00);
    tick();
    chk("edge_e3", pending, 8'h01);
    chk("edge_e3_int", interrupts, 8'h01);
    @(negedge clk);
    irq_in = 8'h00;
    repeat (3) @(negedge clk);
    irq_in = 8'h01;
    repeat (3) @(negedge clk);
    irq_in = 8'h00;
    repeat (4) tick();
    chk("ovr_set", overrun, 8'h01);
    chk("ovr_pend", pending, 8'h01);

    // Clears, then auto-acknowledge of lowest pending line.
    @(negedge clk);
    clr_we = 1'b1; clr_data = 8'h01;
    ovr_clr_we = 1'b1; ovr_clr_data = 8'h01;
    tick();
    chk("clr_pend", pending, 8'h00);
    chk("clr_ovr", overrun, 8'h00);
    @(negedge clk);
    clr_we = 1'b0; ovr_clr_we = 1'b0;
    swi_we = 1'b1; swi_data = 8'h06;
    tick();
    chk("swi_pend", pending, 8'h06);
    @(negedge clk);
    swi_we = 1'b0;
    mask = 8'hFF;
    irq_busy = 1'b1;
    tick();
    chk("ack_idx", {5'd0, taken_idx}, 8'd1);
    chk("ack_valid", {7'd0, taken_valid}, 8'd1);
    chk("ack_pend", pending, 8'h04);
    tick();
    chk("ack_pulse_end", {7'd0, taken_valid}, 8'd0);
    @(negedge clk);
    irq_busy = 1'b0;
    clr_we = 1'b1; clr_data = 8'h04;
    tick();
    chk("clr4", pending, 8'h00);

    // Level line: not latched, clear has no effect.
    @(negedge clk);
    clr_we = 1'b0;
    edge_sel = 8'h00;
    irq_in = 8'h20;
    tick();
    chk("lvl_e1", interrupts, 8'h00);
    tick();
    chk("lvl_e2", interrupts, 8'h20);
    @(negedge clk);
    clr_we = 1'b1; clr_data = 8'h20;
    tick();
    chk("lvl_clr_int", interrupts, 8'h20);
    chk("lvl_clr_pend", pending, 8'h00);
    @(negedge clk);
    clr_we = 1'b0;
    irq_in = 8'h00;
    tick();
    chk("lvl_drop_e1", interrupts, 8'h20);
    tick();
    chk("lvl_drop_e2", interrupts, 8'h00);

    // Set beats clear; masked rise takes nothing; set beats auto-ack.
    @(negedge clk);
    swi_we = 1'b1; swi_data = 8'h08;
    tick();
    chk("swi8", pending, 8'h08);
    @(negedge clk);
    clr_we = 1'b1; clr_data = 8'h08;
    tick();
    chk("set_beats_clr", pending, 8'h08);
    @(negedge clk);
    swi_we = 1'b0; clr_we = 1'b0;
    mask = 8'h00;
    irq_busy = 1'b1;
    tick();
    chk("masked_valid", {7'd0, taken_valid}, 8'd0);
    chk("masked_pend", pending, 8'h08);
    chk("masked_idx", {5'd0, taken_idx}, 8'd1);
    @(negedge clk);
    irq_busy = 1'b0;
    mask = 8'hFF;
    @(negedge clk);
    irq_busy = 1'b1;
    swi_we = 1'b1; swi_data = 8'h08;
    tick();
    chk("ackset_valid", {7'd0, taken_valid}, 8'd1);
    chk("ackset_idx", {5'd0, taken_idx}, 8'd3);
    chk("ackset_pend", pending, 8'h08);
    @(negedge clk);
    irq_busy = 1'b0;
    swi_we = 1'b0;

    // Mixed traffic checked by the model.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) irq_in = 8'($urandom);
      if (c % 50 == 0) edge_sel = 8'($urandom);
      if (c % 37 == 0) mask = 8'($urandom);
      swi_we = ($urandom_range(7) == 0);
      swi_data = 8'($urandom);
      clr_we = ($urandom_range(5) == 0);
      clr_data = 8'($urandom);
      ovr_clr_we = ($urandom_range(9) == 0);
      ovr_clr_data = 8'($urandom);
      if ($urandom_range(3) == 0) irq_busy = ~irq_busy;
    end
    @(negedge clk);
    irq_in = 8'h00; swi_we = 1'b0; clr_we = 1'b0; ovr_clr_we = 1'b0;
    irq_busy = 1'b0; mask = 8'hFF;
    repeat (4) @(negedge clk);

    // Reset during an acknowledge.
    swi_we = 1'b1; swi_data = 8'hF0;
    clr_we = 1'b1; clr_data = 8'hFF;
    tick();
    chk("pend_f0", pending, 8'hF0);
    @(negedge clk);
    swi_we = 1'b0; clr_we = 1'b0;
    irq_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pend", pending, 8'h00);
    chk("mid_rst_int", interrupts, 8'h00);
    chk("mid_rst_ovr", overrun, 8'h00);
    chk("mid_rst_idx", {5'd0, taken_idx}, 8'd0);
    chk("mid_rst_valid", {7'd0, taken_valid}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_valid", {7'd0, taken_valid}, 8'd0);
    end
    @(negedge clk);
    irq_busy = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
